// File: rtl/ethernet_ingress_buffer.sv
// ethernet_ingress_buffer: store-and-forward ingress FIFO with framing/length/destination checks
module ethernet_ingress_buffer #(
  parameter int          DEPTH         = 64,
  parameter int          MAX_PKT_WORDS = 32,
  parameter int          MIN_PKT_WORDS = 2,
  parameter logic [15:0] PORTA_ADDR    = 16'h00AA,
  parameter logic [15:0] PORTB_ADDR    = 16'h00BB,
  parameter int          STALL_THRESH  = 32,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inData,
  input  logic             inSop,
  input  logic             inEop,
  output logic             portStall,
  output logic [31:0]      outData,
  output logic             outSop,
  output logic             outEop,
  output logic             outValid,
  input  logic             outReady,
  output logic             outDest,
  output logic [CNT_W-1:0] pktCnt,
  output logic [CNT_W-1:0] dropCnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t          state, nxt_state;
  logic [PW-1:0]   wr, cm, rd, nxt_wr, nxt_cm, base, free, free_b;
  logic [LW-1:0]   len, nxt_len;
  logic            bad, nxt_bad, we, pkt_inc, dest_ok, load;
  logic [1:0]      drop_inc;
  logic [CNT_W:0]  drop_sum;
  logic [33:0]     mem [DEPTH];
  logic [33:0]     head;

  // A re-SOP inside RECV rewinds to the commit pointer before the new header is written
  assign base     = (state == RECV && inSop) ? cm : wr;
  assign dest_ok  = inData[31:16] == PORTA_ADDR || inData[31:16] == PORTB_ADDR;
  assign free     = PW'(DEPTH) - (wr - rd);
  assign free_b   = PW'(DEPTH) - (base - rd);
  assign head     = mem[rd[AW-1:0]];
  assign load     = (!outValid || outReady) && rd != cm;
  assign drop_sum = {1'b0, dropCnt} + (CNT_W+1)'(drop_inc);

  always_comb begin
    nxt_state = state;
    nxt_wr    = wr;
    nxt_cm    = cm;
    nxt_len   = len;
    nxt_bad   = bad;
    we        = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 2'd0;
    if (state == RECV && !inSop) begin
      if (free == '0 || len >= LW'(MAX_PKT_WORDS)) begin
        nxt_wr    = cm;
        drop_inc  = 2'd1;
        nxt_bad   = 1'b0;
        nxt_state = inEop ? IDLE : DROP;
      end else begin
        we      = 1'b1;
        nxt_wr  = wr + PW'(1);
        nxt_len = len + LW'(1);
        if (inEop) begin
          nxt_state = IDLE;
          if (len >= LW'(MIN_PKT_WORDS - 1)) begin
            nxt_cm  = wr + PW'(1);
            pkt_inc = 1'b1;
          end else begin
            nxt_wr   = cm;
            drop_inc = 2'd1;
          end
        end
      end
    end else if (state == DROP && !inSop) begin
      if (inEop) begin
        nxt_state = IDLE;
        drop_inc  = {1'b0, bad};
      end
    end else if (inSop) begin
      drop_inc = {1'b0, state == RECV};
      nxt_wr   = base;
      if (inEop) begin
        drop_inc  = drop_inc + 2'd1;
        nxt_state = IDLE;
      end else if (!dest_ok) begin
        nxt_state = DROP;
        nxt_bad   = 1'b1;
      end else if (free_b == '0) begin
        drop_inc  = drop_inc + 2'd1;
        nxt_state = DROP;
        nxt_bad   = 1'b0;
      end else begin
        we        = 1'b1;
        nxt_wr    = base + PW'(1);
        nxt_len   = LW'(1);
        nxt_state = RECV;
      end
    end
  end

  always_ff @(posedge clk)
    if (we) mem[base[AW-1:0]] <= {inSop, inEop, inData};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr        <= '0;
      cm        <= '0;
      rd        <= '0;
      len       <= '0;
      bad       <= 1'b0;
      portStall <= 1'b0;
      outData   <= '0;
      outSop    <= 1'b0;
      outEop    <= 1'b0;
      outValid  <= 1'b0;
      outDest   <= 1'b0;
      pktCnt    <= '0;
      dropCnt   <= '0;
    end else begin
      state     <= nxt_state;
      wr        <= nxt_wr;
      cm        <= nxt_cm;
      len       <= nxt_len;
      bad       <= nxt_bad;
      portStall <= free < PW'(STALL_THRESH);
      pktCnt    <= pktCnt + CNT_W'(pkt_inc && pktCnt != '1);
      dropCnt   <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      if (load) begin
        rd                        <= rd + PW'(1);
        outValid                  <= 1'b1;
        {outSop, outEop, outData} <= head;
        if (head[33]) outDest <= head[31:16] == PORTB_ADDR;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ethernet_ingress_buffer.sv
// tb_ethernet_ingress_buffer: packet table plus corner-case sequences, scoreboard on the fabric side
module tb_ethernet_ingress_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inData;
  logic        inSop, inEop, outReady;
  logic        portStall, outSop, outEop, outValid, outDest;
  logic [31:0] outData;
  logic [15:0] pktCnt, dropCnt;

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  logic [63:0] q[$];

  typedef struct {
    logic [31:0] hdr;
    int          len;
    logic        pass;
    logic        dest;
    int          dpkt;
    int          ddrop;
  } vec_t;
  vec_t tbl[8];

  ethernet_ingress_buffer dut (
    .clk(clk), .reset(reset), .inData(inData), .inSop(inSop), .inEop(inEop),
    .portStall(portStall), .outData(outData), .outSop(outSop), .outEop(outEop),
    .outValid(outValid), .outReady(outReady), .outDest(outDest),
    .pktCnt(pktCnt), .dropCnt(dropCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && outValid && outReady) begin
      if (q.size() == 0) chk("unexpected_word", {29'b0, outDest, outSop, outEop, outData}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("out_word", {29'b0, outDest, outSop, outEop, outData}, q.pop_front());
    end
  end

  task automatic send(input logic [31:0] hdr, input int n, input logic eop, input logic push, input logic dest);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = (i == 0) ? hdr : {8'hD0, hdr[7:0], i[15:0]};
      inData = d;
      inSop  = (i == 0);
      inEop  = eop && (i == n - 1);
      if (push) q.push_back({29'b0, dest, i == 0, eop && (i == n - 1), d});
      @(posedge clk); #1;
    end
    inSop = 1'b0; inEop = 1'b0; inData = '0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 300 && (q.size() != 0 || outValid); c++) begin
      @(posedge clk); #1;
    end
    chk("drain_done", {63'b0, q.size() != 0 || outValid}, 64'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pktCnt"}, 64'(pktCnt), 64'(exp_pkt));
    chk({tag, "_dropCnt"}, 64'(dropCnt), 64'(exp_drop));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, {28'b0, portStall, outValid, outSop, outEop, outDest, outData}, 64'd0);
    chk_counts(tag);
  endtask

  task automatic latency_pkt(input string tag);
    outReady = 1'b1;
    send(32'h00AA_0001, 4, 1'b1, 1'b1, 1'b0);
    chk({tag, "_valid_early"}, {63'b0, outValid}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_first"}, {29'b0, outValid, outSop, outDest, outData}, {29'b0, 3'b110, 32'h00AA_0001});
    wait_drain();
    exp_pkt++;
    chk_counts(tag);
  endtask

  initial begin
    tbl[0] = '{32'h00AA_0010, 4, 1'b1, 1'b0, 1, 0};
    tbl[1] = '{32'h00BB_0011, 6, 1'b1, 1'b1, 1, 0};
    tbl[2] = '{32'h00CC_0003, 5, 1'b0, 1'b0, 0, 1};
    tbl[3] = '{32'h00AA_0012, 1, 1'b0, 1'b0, 0, 1};
    tbl[4] = '{32'h00AA_0013, 2, 1'b1, 1'b0, 1, 0};
    tbl[5] = '{32'h00BB_0014, 32, 1'b1, 1'b1, 1, 0};
    tbl[6] = '{32'h00AA_0015, 33, 1'b0, 1'b0, 0, 1};
    tbl[7] = '{32'h1234_0016, 2, 1'b0, 1'b0, 0, 1};

    reset = 1'b0; inData = '0; inSop = 1'b0; inEop = 1'b0; outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    latency_pkt("t1");

    outReady = 1'b0;
    send(32'h00BB_0002, 4, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_hold_a", {29'b0, outValid, outSop, outDest, outData}, {29'b0, 3'b111, 32'h00BB_0002});
    repeat (8) @(posedge clk);
    #1;
    chk("t2_hold_b", {29'b0, outValid, outSop, outDest, outData}, {29'b0, 3'b111, 32'h00BB_0002});
    outReady = 1'b1;
    wait_drain();
    exp_pkt++;
    chk_counts("t2");

    foreach (tbl[k]) begin
      send(tbl[k].hdr, tbl[k].len, 1'b1, tbl[k].pass, tbl[k].dest);
      wait_drain();
      exp_pkt += tbl[k].dpkt;
      exp_drop += tbl[k].ddrop;
      chk_counts($sformatf("tbl%0d", k));
    end

    send(32'h00AA_0020, 4, 1'b0, 1'b0, 1'b0);
    send(32'h00AA_0021, 3, 1'b1, 1'b1, 1'b0);
    wait_drain();
    exp_pkt++;
    exp_drop++;
    chk_counts("t4");

    outReady = 1'b0;
    send(32'h00AA_0030, 32, 1'b1, 1'b1, 1'b0);
    send(32'h00BB_0031, 32, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("t5_stall_on", {63'b0, portStall}, 64'd1);
    send(32'h00AA_0032, 32, 1'b1, 1'b0, 1'b0);
    exp_pkt += 2;
    exp_drop++;
    chk_counts("t5_full");
    outReady = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while (q.size() != 0 && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("t5_drain_cycles", 64'(cyc), 64'd64);
    end
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    chk("t5_stall_off", {63'b0, portStall}, 64'd0);

    send(32'h00AA_0040, 3, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    exp_pkt = 0;
    exp_drop = 0;
    chk_zero("t6_midpkt");
    @(posedge clk); #1;
    reset = 1'b1;
    outReady = 1'b0;
    send(32'h00AA_0041, 4, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    outReady = 1'b1;
    @(posedge clk); #1;
    #3 reset = 1'b0;
    #1;
    q.delete();
    chk_zero("t6_middrain");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    latency_pkt("t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
